// File: rtl/anfsqrt_pkg.sv
// Shared Q16.16 constants for the ANF sqrt datapath.
// Holds only parameters; no logic, so there is no latency or backpressure here.
package anfsqrt_pkg;

  localparam int unsigned Q_W       = 32;
  localparam int unsigned FRAC_BITS = 16;

  localparam logic [Q_W-1:0] INIT_ATT = 32'h0001_0000;
  localparam logic [Q_W-1:0] INIT_EPS = 32'd256;

endpackage

// File: rtl/anfsqrt_sqrtiu_step.sv
// One square-root search trial: evaluate prev_att against rad, produce the next att/eps/res.
// Purely combinational (zero latency); it never stalls.
module anfsqrt_sqrtiu_step
  import anfsqrt_pkg::*;
(
  input  logic [Q_W-1:0] prev_att,
  input  logic [Q_W-1:0] prev_eps,
  input  logic [Q_W-1:0] prev_res,
  input  logic           grow,
  input  logic [Q_W-1:0] rad,
  output logic [Q_W-1:0] this_att,
  output logic [Q_W-1:0] this_eps,
  output logic [Q_W-1:0] this_res,
  output logic           next_grow,
  output logic           finish
);

  logic [2*Q_W-1:0] prod;
  logic [2*Q_W-1:0] limit;
  logic             ok;
  logic [Q_W:0]     eps_dbl;
  logic [Q_W:0]     att_grow;
  logic             grow_ovf;

  assign prod  = 64'(prev_att) * 64'(prev_att);
  // (prod >> 16) <= rad, with no high bits set, is the same as prod <= {rad, all-ones fraction}.
  assign limit = {{(Q_W-FRAC_BITS){1'b0}}, rad, {FRAC_BITS{1'b1}}};
  assign ok    = (prod <= limit);

  assign eps_dbl  = {prev_eps, 1'b0};
  assign att_grow = {1'b0, prev_att} + eps_dbl;
  assign grow_ovf = eps_dbl[Q_W] | att_grow[Q_W];

  always_comb begin
    next_grow = grow;
    this_res  = prev_res;
    this_eps  = prev_eps >> 1;
    this_att  = prev_res + (prev_eps >> 1);
    if (ok && grow && !grow_ovf) begin
      this_res = prev_att;
      this_eps = eps_dbl[Q_W-1:0];
      this_att = att_grow[Q_W-1:0];
    end else if (ok && !grow) begin
      this_res = prev_att;
      this_att = prev_att + (prev_eps >> 1);
    end else begin
      // Rejected trial, or a grow step that would wrap: switch to halving around res.
      next_grow = 1'b0;
    end
  end

  assign finish = (this_eps == '0);

endmodule

// File: rtl/anfsqrt_sqrt_iu.sv
// Iterative Q16.16 square root: galloping then binary search, one trial per clock.
// Latency = grow trials + log2(final eps) + 1 cycles; no backpressure, start restarts at any time.
module anfsqrt_sqrt_iu
  import anfsqrt_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [Q_W-1:0] radicand,
  output logic [Q_W-1:0] this_att,
  output logic [Q_W-1:0] this_eps,
  output logic [Q_W-1:0] this_res,
  output logic           busy,
  output logic           done
);

  logic [Q_W-1:0] rad;
  logic           grow;
  logic [Q_W-1:0] nxt_att;
  logic [Q_W-1:0] nxt_eps;
  logic [Q_W-1:0] nxt_res;
  logic           nxt_grow;
  logic           finish;

  anfsqrt_sqrtiu_step u_step (
    .prev_att  (this_att),
    .prev_eps  (this_eps),
    .prev_res  (this_res),
    .grow      (grow),
    .rad       (rad),
    .this_att  (nxt_att),
    .this_eps  (nxt_eps),
    .this_res  (nxt_res),
    .next_grow (nxt_grow),
    .finish    (finish)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rad      <= '0;
      this_att <= '0;
      this_eps <= '0;
      this_res <= '0;
      grow     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      rad      <= radicand;
      this_att <= INIT_ATT;
      this_eps <= INIT_EPS;
      this_res <= '0;
      grow     <= 1'b1;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else if (busy) begin
      this_att <= nxt_att;
      this_eps <= nxt_eps;
      this_res <= nxt_res;
      grow     <= nxt_grow;
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_anfsqrt_sqrt_iu.sv
// Self-checking bench for anfsqrt_sqrt_iu against an arithmetic square-root reference.
module tb_anfsqrt_sqrt_iu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] radicand;
  logic [31:0] this_att;
  logic [31:0] this_eps;
  logic [31:0] this_res;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  anfsqrt_sqrt_iu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .radicand (radicand),
    .this_att (this_att),
    .this_eps (this_eps),
    .this_res (this_res),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Largest v with (v*v)>>16 <= r. When r < 1.0 the first trial (1.0) is rejected,
  // which confines the search to v < 256.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] r);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 25;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (((mid * mid) >> 16) <= 64'(r)) lo = mid;
      else hi = mid;
    end
    if (r < 32'h0001_0000 && lo > 255) lo = 255;
    return lo[31:0];
  endfunction

  task automatic do_search(input logic [31:0] r, input logic [31:0] exp_res);
    int cyc;
    @(posedge clk); #1;
    start = 1'b1;
    radicand = r;
    @(posedge clk); #1;
    start = 1'b0;
    radicand = $urandom();
    checks++;
    if (this_att !== 32'h0001_0000 || this_eps !== 32'd256 || this_res !== 32'd0 ||
        busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL load r=%h: att=%h eps=%h res=%h busy=%b done=%b, want 00010000 00000100 0 1 0",
               r, this_att, this_eps, this_res, busy, done);
    end
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!done || cyc > 72) begin
      errors++;
      $display("FAIL latency r=%h: done=%b after %0d cycles, want done within 72", r, done, cyc);
    end
    checks++;
    if (this_res !== exp_res) begin
      errors++;
      $display("FAIL result r=%h: res=%h, want %h", r, this_res, exp_res);
    end
    checks++;
    if (this_att !== exp_res || this_eps !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final r=%h: att=%h eps=%h busy=%b, want att=%h eps=0 busy=0",
               r, this_att, this_eps, busy, exp_res);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || this_res !== exp_res || this_eps !== 32'd0) begin
      errors++;
      $display("FAIL hold r=%h: done=%b res=%h eps=%h, want 1 %h 0", r, done, this_res, this_eps, exp_res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    radicand = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (this_att !== 32'd0 || this_eps !== 32'd0 || this_res !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: att=%h eps=%h res=%h busy=%b done=%b, want all 0",
               this_att, this_eps, this_res, busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || this_att !== 32'd0) begin
      errors++;
      $display("FAIL idle: busy=%b done=%b att=%h, want 0 0 0", busy, done, this_att);
    end
  endtask

  task automatic test_directed();
    do_search(32'h0004_0000, 32'h0002_0000);
    do_search(32'h0002_0000, 32'h0001_6A0A);
    do_search(32'h0000_0000, 32'h0000_00FF);
    do_search(32'hFFFF_FFFF, 32'h00FF_FFFF);
    do_search(32'h0001_0000, ref_sqrt(32'h0001_0000));
    do_search(32'h0000_8000, ref_sqrt(32'h0000_8000));
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 24; i++) begin
      r = $urandom();
      if (i % 3 == 1) r = r >> $urandom_range(0, 31);
      if (i % 3 == 2) r = 32'h0001_0000 + $urandom_range(0, 255) - 128;
      do_search(r, ref_sqrt(r));
    end
  endtask

  task automatic test_restart();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom();
    b = $urandom() >> 4;
    @(posedge clk); #1;
    start = 1'b1;
    radicand = a;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    do_search(b, ref_sqrt(b));
  endtask

  task automatic test_reset_mid();
    logic [31:0] b;
    @(posedge clk); #1;
    start = 1'b1;
    radicand = $urandom();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (this_att !== 32'd0 || this_eps !== 32'd0 || this_res !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: att=%h eps=%h res=%h busy=%b done=%b, want all 0",
               this_att, this_eps, this_res, busy, done);
    end
    rst_n = 1'b1;
    start = 1'b0;
    b = $urandom();
    do_search(b, ref_sqrt(b));
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r = $urandom() >> (i * 7);
      do_search(r, ref_sqrt(r));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    radicand = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
